fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 111 +++++++++++
 tb/tb_fetch_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks a combinational ROM and hands one word per cycle to execute.
// Optional FETCH_JUMP_PREDECODE_EN folds absolute jumps (opcode 4'b1000) into fetch.
module fetch_sequencer #(
    parameter logic [9:0] RESET_PC  = 10'd0,
    parameter logic [9:0] HALT_WORD = 10'b0010000010
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [9:0] start_pc,
    output logic [9:0] rom_address,
    input  logic [9:0] rom_data,
    output logic [9:0] instr,
    output logic [9:0] instr_pc,
    output logic       instr_valid,
    input  logic       instr_ready,
    input  logic       redirect,
    input  logic [9:0] redirect_pc,
    output logic       busy,
    output logic       halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t     state_reg;
    logic [9:0] pc_reg;
    logic [9:0] instr_reg;
    logic [9:0] instr_pc_reg;
    logic       instr_valid_reg;
    logic       busy_reg;
    logic       halted_reg;

    logic slot_free;
    logic is_halt;

    assign slot_free = ~instr_valid_reg | instr_ready;
    assign is_halt   = (rom_data == HALT_WORD);

`ifdef FETCH_JUMP_PREDECODE_EN
    logic is_jump;
    assign is_jump = (rom_data[9:6] == 4'b1000);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            pc_reg          <= RESET_PC;
            instr_reg       <= 10'd0;
            instr_pc_reg    <= 10'd0;
            instr_valid_reg <= 1'b0;
            busy_reg        <= 1'b0;
            halted_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, HALT: begin
                    if (start) begin
                        pc_reg          <= start_pc;
                        instr_valid_reg <= 1'b0;
                        state_reg       <= FETCH;
                        busy_reg        <= 1'b1;
                        halted_reg      <= 1'b0;
                    end else if (instr_valid_reg && instr_ready) begin
                        // A halt word left pending downstream retires here.
                        instr_valid_reg <= 1'b0;
                    end
                end
                FETCH: begin
                    if (redirect) begin
                        pc_reg          <= redirect_pc;
                        instr_valid_reg <= 1'b0;
`ifdef FETCH_JUMP_PREDECODE_EN
                    end else if (slot_free && is_jump) begin
                        // Jump is consumed in fetch; the slot is free, so whatever was
                        // shown has either just transferred or was already empty.
                        pc_reg          <= {4'b0000, rom_data[5:0]};
                        instr_valid_reg <= 1'b0;
`endif
                    end else if (slot_free) begin
                        instr_reg       <= rom_data;
                        instr_pc_reg    <= pc_reg;
                        instr_valid_reg <= 1'b1;
                        if (is_halt) begin
                            state_reg  <= HALT;
                            busy_reg   <= 1'b0;
                            halted_reg <= 1'b1;
                        end else begin
                            pc_reg <= pc_reg + 10'd1;
                        end
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    busy_reg   <= 1'b0;
                    halted_reg <= 1'b0;
                end
            endcase
        end
    end

    assign rom_address = pc_reg;
    assign instr       = instr_reg;
    assign instr_pc    = instr_pc_reg;
    assign instr_valid = instr_valid_reg;
    assign busy        = busy_reg;
    assign halted      = halted_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed steps plus a randomized
// ready/redirect phase checked against an in-order instruction-stream model.
module tb_fetch_sequencer;

    localparam logic [9:0] HALT_W = 10'b0010000010;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] start_pc = 10'd0;
    logic [9:0] rom_address;
    logic [9:0] rom_data;
    logic [9:0] instr;
    logic [9:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready = 1'b0;
    logic       redirect = 1'b0;
    logic [9:0] redirect_pc = 10'd0;
    logic       busy;
    logic       halted;

    logic [9:0] rom [1024];
    int errors = 0;
    int checks = 0;

    assign rom_data = rom[rom_address];

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(10'd0), .HALT_WORD(HALT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
        .rom_address(rom_address), .rom_data(rom_data),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .busy(busy), .halted(halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ordinary word: neither the halt encoding nor a jump opcode.
    function automatic logic [9:0] plain_word();
        logic [9:0] w;
        do w = 10'($urandom_range(0, 1023));
        while (w == HALT_W || w[9:6] == 4'b1000);
        return w;
    endfunction

    initial begin
        logic [9:0] exp_next;
        int         xfers;
        int         got_n;
        logic [9:0] got [3];
        logic [9:0] want [3];

        for (int i = 0; i < 1024; i++) rom[i] = plain_word();
        rom[0] = 10'h370;
        rom[1] = 10'h36D;
        rom[2] = 10'h029;

        // Reset values
        #3;
        chk("rst_valid", instr_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc", rom_address, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Start at 0, first valid two edges after start is driven
        instr_ready = 1'b1;
        start = 1'b1;
        start_pc = 10'd0;
        tick();
        start = 1'b0;
        chk("start_valid0", instr_valid, 0);
        chk("start_busy", busy, 1);
        chk("start_addr", rom_address, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("stream_valid", instr_valid, 1);
            chk("stream_pc", instr_pc, k);
            chk("stream_instr", instr, rom[k]);
        end
        $display("step: start stream 0..5 done");

        // Stall with instr_pc=5 shown
        instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_pc", instr_pc, 5);
            chk("stall_instr", instr, rom[5]);
            chk("stall_valid", instr_valid, 1);
            chk("stall_addr", rom_address, 6);
        end
        instr_ready = 1'b1;
        tick();
        chk("unstall_pc", instr_pc, 6);
        chk("unstall_addr", rom_address, 7);
        $display("step: stall at 5 done");

        // Redirect to 18 when PC=10
        for (int k = 0; k < 10 && rom_address != 10'd10; k++) tick();
        chk("pre_redir_addr", rom_address, 10);
        redirect = 1'b1;
        redirect_pc = 10'd18;
        tick();
        redirect = 1'b0;
        chk("redir_valid0", instr_valid, 0);
        chk("redir_addr", rom_address, 18);
        tick();
        chk("redir_valid1", instr_valid, 1);
        chk("redir_pc", instr_pc, 18);
        $display("step: redirect to 18 done");

        // Randomized ready/redirect against in-order stream model
        exp_next = 10'd18;
        xfers = 0;
        for (int n = 0; n < 400; n++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 15) == 0);
            redirect_pc = 10'($urandom_range(0, 1023));
            if (instr_valid && instr_ready) begin
                chk("rand_pc", instr_pc, exp_next);
                chk("rand_instr", instr, rom[exp_next]);
                exp_next = exp_next + 10'd1;
                xfers++;
            end
            if (redirect) exp_next = redirect_pc;
            tick();
        end
        redirect = 1'b0;
        checks++;
        assert (xfers > 100) else begin
            errors++;
            $error("FAIL rand_xfers observed=%0d expected=>100", xfers);
        end
        chk("rand_busy", busy, 1);
        $display("step: random phase %0d transfers", xfers);

        // Halt at 31
        rom[31] = HALT_W;
        instr_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 10'd28;
        tick();
        redirect = 1'b0;
        chk("h_valid0", instr_valid, 0);
        for (int k = 28; k < 32; k++) begin
            tick();
            chk("h_stream_pc", instr_pc, k);
        end
        chk("h_halted", halted, 1);
        chk("h_busy", busy, 0);
        chk("h_addr", rom_address, 31);
        chk("h_instr", instr, HALT_W);
        chk("h_valid", instr_valid, 1);
        instr_ready = 1'b0;
        tick();
        tick();
        chk("h_hold_valid", instr_valid, 1);
        chk("h_hold_pc", instr_pc, 31);
        chk("h_hold_addr", rom_address, 31);
        instr_ready = 1'b1;
        tick();
        chk("h_taken_valid", instr_valid, 0);
        chk("h_taken_halted", halted, 1);
        redirect = 1'b1;
        redirect_pc = 10'd100;
        tick();
        redirect = 1'b0;
        chk("h_ignore_redir", rom_address, 31);
        chk("h_still_halted", halted, 1);
        start = 1'b1;
        start_pc = 10'd0;
        tick();
        start = 1'b0;
        chk("restart_busy", busy, 1);
        chk("restart_halted", halted, 0);
        chk("restart_addr", rom_address, 0);
        chk("restart_valid0", instr_valid, 0);
        tick();
        chk("restart_pc", instr_pc, 0);
        chk("restart_instr", instr, 10'h370);
        start = 1'b1;
        start_pc = 10'd500;
        tick();
        start = 1'b0;
        chk("fetch_ignore_start_pc", instr_pc, 1);
        chk("fetch_ignore_start_addr", rom_address, 2);
        $display("step: halt and restart done");

        // Asynchronous reset mid-fetch
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", instr_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_addr", rom_address, 0);
        chk("arst_instr", instr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("arst_idle_busy", busy, 0);
        chk("arst_idle_valid", instr_valid, 0);

        // Wrap at 1023
        start = 1'b1;
        start_pc = 10'd1023;
        tick();
        start = 1'b0;
        tick();
        chk("wrap_pc1023", instr_pc, 1023);
        chk("wrap_instr", instr, rom[1023]);
        tick();
        chk("wrap_pc0", instr_pc, 0);
        $display("step: reset and wrap done");

        // Jump word at 7
        rom[7] = 10'b1000001001;
`ifdef FETCH_JUMP_PREDECODE_EN
        want[0] = 10'd6; want[1] = 10'd9; want[2] = 10'd10;
`else
        want[0] = 10'd6; want[1] = 10'd7; want[2] = 10'd8;
`endif
        redirect = 1'b1;
        redirect_pc = 10'd6;
        tick();
        redirect = 1'b0;
        got_n = 0;
        for (int k = 0; k < 10 && got_n < 3; k++) begin
            tick();
            if (instr_valid) begin
                got[got_n] = instr_pc;
                got_n++;
            end
        end
        chk("jump_count", got_n, 3);
        for (int k = 0; k < 3; k++) begin
            if (k < got_n) chk("jump_seq", got[k], want[k]);
        end
        $display("step: jump word sequence done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
